// File: rtl/prog_load_ctrl.sv
// Program loader: assembles UART byte pairs into 16-bit words for the program RAM
// and toggles between load and run mode on a long press of the mode button.
module prog_load_ctrl #(
    parameter int HOLD_CYCLES  = 13500000,
    parameter int BYTE_TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        ram_we,
    output logic [7:0]  ram_waddr,
    output logic [15:0] ram_wdata,
    output logic        cpu_rst,
    output logic        mode,
    output logic [8:0]  word_count,
    output logic        load_err
);

    localparam logic [23:0] HOLD_MAX  = 24'(HOLD_CYCLES);
    localparam logic [11:0] TO_MAX    = 12'(BYTE_TIMEOUT);
    localparam logic [8:0]  COUNT_MAX = 9'd256;

    typedef enum logic [1:0] {
        LOAD_LO,
        LOAD_HI,
        WRITE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [8:0]  count_q, count_d;
    logic        err_q, err_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic [23:0] hold_q, hold_d;
    logic [11:0] to_q, to_d;
    logic        toggle;

    // The hold counter parks at HOLD_MAX, so the toggle fires only on the cycle it arrives there.
    always_comb begin
        hold_d = hold_q;
        toggle = 1'b0;
        if (button) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 24'd1;
            toggle = (hold_d == HOLD_MAX);
        end
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        to_d    = '0;
        case (state_q)
            LOAD_LO: begin
                if (toggle) begin
                    state_d = RUN;
                end else if (rx_valid) begin
                    lo_d    = rx_data;
                    state_d = LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (toggle) begin
                    err_d   = 1'b1;
                    state_d = RUN;
                end else if (rx_valid) begin
                    wdata_d = {rx_data, lo_q};
                    state_d = WRITE;
                end else if (to_q + 12'd1 == TO_MAX) begin
                    err_d   = 1'b1;
                    state_d = LOAD_LO;
                end else begin
                    to_d = to_q + 12'd1;
                end
            end
            WRITE: begin
                addr_d = addr_q + 8'd1;
                if (count_q != COUNT_MAX) begin
                    count_d = count_q + 9'd1;
                end
                // A byte arriving during the write strobe starts the next word immediately.
                if (toggle) begin
                    state_d = RUN;
                end else if (rx_valid) begin
                    lo_d    = rx_data;
                    state_d = LOAD_HI;
                end else begin
                    state_d = LOAD_LO;
                end
            end
            RUN: begin
                if (toggle) begin
                    state_d = LOAD_LO;
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = LOAD_LO;
        endcase
        // CPU reset releases one cycle after entering run, but reasserts on the leaving edge.
        cpu_rst_d = !((state_q == RUN) && (state_d == RUN));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD_LO;
            lo_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            hold_q    <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            count_q   <= count_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
            hold_q    <= hold_d;
            to_q      <= to_d;
        end
    end

    // Gating with reset keeps a pending write from strobing during the reset cycle.
    assign ram_we     = (state_q == WRITE) && !reset;
    assign ram_waddr  = addr_q;
    assign ram_wdata  = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign mode       = (state_q == RUN);
    assign word_count = count_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Randomised self-checking bench for prog_load_ctrl; expected RAM writes come from
// a byte-pair model of the loader protocol and are compared against a captured write log.
module tb_prog_load_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        button;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        ram_we;
    logic [7:0]  ram_waddr;
    logic [15:0] ram_wdata;
    logic        cpu_rst;
    logic        mode;
    logic [8:0]  word_count;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t captured[$];

    always #5 clk = ~clk;

    prog_load_ctrl #(.HOLD_CYCLES(20), .BYTE_TIMEOUT(50)) dut (
        .clk        (clk),
        .reset      (reset),
        .button     (button),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .cpu_rst    (cpu_rst),
        .mode       (mode),
        .word_count (word_count),
        .load_err   (load_err)
    );

    always @(negedge clk) begin
        if (ram_we === 1'b1) captured.push_back({ram_waddr, ram_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        button   = 1'b1;
        rx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        captured.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        button   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        tick();
        checks++; if (mode !== 1'b0) begin errors++; $display("[TB] FAIL reset_mode got=%0h exp=0", mode); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_cpu_rst got=%0h exp=1", cpu_rst); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we got=%0h exp=0", ram_we); end
        checks++; if (ram_waddr !== 8'h00) begin errors++; $display("[TB] FAIL reset_waddr got=%0h exp=0", ram_waddr); end
        checks++; if (ram_wdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wdata got=%0h exp=0", ram_wdata); end
        checks++; if (word_count !== 9'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", word_count); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%0h exp=0", load_err); end
        reset = 1'b0;
        captured.delete();
    endtask

    task automatic test_single_word();
        do_reset();
        send_byte(8'h34, 2);
        send_byte(8'h12, 3);
        checks++; if (captured.size() != 1) begin errors++; $display("[TB] FAIL single_nwrites got=%0d exp=1", captured.size()); end
        if (captured.size() >= 1) begin
            checks++;
            if (captured[0] !== {8'h00, 16'h1234}) begin
                errors++; $display("[TB] FAIL single_write got=%0h/%0h exp=0/1234", captured[0].addr, captured[0].data);
            end
        end
        checks++; if (word_count !== 9'd1) begin errors++; $display("[TB] FAIL single_count got=%0d exp=1", word_count); end
        checks++; if (ram_waddr !== 8'h01) begin errors++; $display("[TB] FAIL single_waddr got=%0h exp=1", ram_waddr); end
        checks++; if (ram_wdata !== 16'h1234) begin errors++; $display("[TB] FAIL single_wdata_hold got=%0h exp=1234", ram_wdata); end
    endtask

    // 257 words with random gaps, including zero gaps that land the next low byte in the write cycle.
    task automatic test_stream_wrap();
        wr_t exp_q[$];
        logic [7:0] lo;
        logic [7:0] hi;
        do_reset();
        for (int i = 0; i < 257; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom);
            send_byte(lo, int'($urandom_range(0, 2)));
            send_byte(hi, int'($urandom_range(0, 2)));
            exp_q.push_back({8'(i % 256), hi, lo});
        end
        repeat (3) tick();
        checks++; if (captured.size() != exp_q.size()) begin errors++; $display("[TB] FAIL stream_nwrites got=%0d exp=%0d", captured.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < captured.size(); i++) begin
            checks++;
            if (captured[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL stream_write[%0d] got=%0h/%0h exp=%0h/%0h", i, captured[i].addr, captured[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++; if (word_count !== 9'd256) begin errors++; $display("[TB] FAIL stream_count_sat got=%0d exp=256", word_count); end
        checks++; if (ram_waddr !== 8'h01) begin errors++; $display("[TB] FAIL stream_waddr got=%0h exp=1", ram_waddr); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL stream_err got=%0h exp=0", load_err); end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h55, 30);
        send_byte(8'h66, 3);
        checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL short_gap_err got=%0h exp=0", load_err); end
        send_byte(8'hAA, 60);
        checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err got=%0h exp=1", load_err); end
        send_byte(8'h01, 1);
        send_byte(8'h02, 3);
        checks++; if (captured.size() != 2) begin errors++; $display("[TB] FAIL timeout_nwrites got=%0d exp=2", captured.size()); end
        if (captured.size() >= 2) begin
            checks++;
            if (captured[0] !== {8'h00, 16'h6655}) begin
                errors++; $display("[TB] FAIL short_gap_write got=%0h/%0h exp=0/6655", captured[0].addr, captured[0].data);
            end
            checks++;
            if (captured[1] !== {8'h01, 16'h0201}) begin
                errors++; $display("[TB] FAIL timeout_write got=%0h/%0h exp=1/0201", captured[1].addr, captured[1].data);
            end
        end
        checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got=%0h exp=1", load_err); end
    endtask

    task automatic test_mode_toggle();
        int first_on;
        int changes;
        logic prev;
        logic rst20;
        logic rst21;
        logic mode19;
        logic [14:0] snap;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'($urandom), 1);
            send_byte(8'($urandom), 1);
        end
        send_byte(8'hAA, 60);
        first_on = -1;
        changes  = 0;
        prev     = mode;
        rst20    = 1'bx;
        rst21    = 1'bx;
        button   = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (mode !== prev) changes++;
            prev = mode;
            if (mode === 1'b1 && first_on < 0) first_on = i;
            if (i == 20) rst20 = cpu_rst;
            if (i == 21) rst21 = cpu_rst;
        end
        button = 1'b1;
        tick();
        checks++; if (first_on != 20) begin errors++; $display("[TB] FAIL toggle_cycle got=%0d exp=20", first_on); end
        checks++; if (changes != 1) begin errors++; $display("[TB] FAIL toggle_count got=%0d exp=1", changes); end
        checks++; if (rst20 !== 1'b1) begin errors++; $display("[TB] FAIL cpu_rst_enter got=%0h exp=1", rst20); end
        checks++; if (rst21 !== 1'b0) begin errors++; $display("[TB] FAIL cpu_rst_release got=%0h exp=0", rst21); end
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
        checks++; if (captured.size() != 3) begin errors++; $display("[TB] FAIL run_ignores_rx got=%0d exp=3", captured.size()); end
        checks++; if (word_count !== 9'd3) begin errors++; $display("[TB] FAIL run_count got=%0d exp=3", word_count); end
        mode19 = 1'bx;
        snap   = 'x;
        button = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 19) mode19 = mode;
            if (i == 20) snap = {mode, cpu_rst, load_err, ram_waddr, word_count[3:0]};
        end
        button = 1'b1;
        tick();
        checks++; if (mode19 !== 1'b1) begin errors++; $display("[TB] FAIL back_early got=%0h exp=1", mode19); end
        checks++; if (snap !== {1'b0, 1'b1, 1'b0, 8'h00, 4'h0}) begin errors++; $display("[TB] FAIL back_to_load got=%0h exp=%0h", snap, {1'b0, 1'b1, 1'b0, 8'h00, 4'h0}); end
        checks++; if (word_count !== 9'd0) begin errors++; $display("[TB] FAIL back_count got=%0d exp=0", word_count); end
        send_byte(8'hCD, 1);
        send_byte(8'hAB, 3);
        checks++;
        if (captured.size() != 4 || captured[captured.size()-1] !== {8'h00, 16'hABCD}) begin
            errors++; $display("[TB] FAIL reload_write got=%0d writes exp=4 ending 0/abcd", captured.size());
        end
    endtask

    task automatic test_toggle_load_hi();
        do_reset();
        send_byte(8'h77, 1);
        button = 1'b0;
        repeat (20) tick();
        button = 1'b1;
        tick();
        checks++; if (mode !== 1'b1) begin errors++; $display("[TB] FAIL hi_toggle_mode got=%0h exp=1", mode); end
        checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL hi_toggle_err got=%0h exp=1", load_err); end
        checks++; if (captured.size() != 0) begin errors++; $display("[TB] FAIL hi_toggle_nwrites got=%0d exp=0", captured.size()); end
    endtask

    task automatic test_reset_mid();
        logic we_in_reset;
        do_reset();
        send_byte(8'h11, 2);
        reset = 1'b1;
        tick();
        checks++; if ({mode, cpu_rst, ram_we, load_err, ram_waddr} !== {4'b0100, 8'h00}) begin
            errors++; $display("[TB] FAIL mid_reset_outs got=%0h exp=%0h", {mode, cpu_rst, ram_we, load_err, ram_waddr}, {4'b0100, 8'h00});
        end
        reset = 1'b0;
        send_byte(8'h78, 1);
        send_byte(8'h56, 3);
        checks++;
        if (captured.size() != 1 || captured[0] !== {8'h00, 16'h5678}) begin
            errors++; $display("[TB] FAIL mid_reset_write got=%0d writes exp=1 of 0/5678", captured.size());
        end
        captured.delete();
        rx_valid = 1'b1;
        rx_data  = 8'h22;
        tick();
        rx_data = 8'h33;
        tick();
        rx_valid = 1'b0;
        reset    = 1'b1;
        #1;
        we_in_reset = ram_we;
        tick();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (we_in_reset !== 1'b0) begin errors++; $display("[TB] FAIL we_in_reset got=%0h exp=0", we_in_reset); end
        checks++; if (captured.size() != 0) begin errors++; $display("[TB] FAIL write_reset_nwrites got=%0d exp=0", captured.size()); end
        checks++; if (ram_waddr !== 8'h00) begin errors++; $display("[TB] FAIL write_reset_waddr got=%0h exp=0", ram_waddr); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stream_wrap();
        test_timeout();
        test_mode_toggle();
        test_toggle_load_hi();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_load_ctrl.md
PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 13500000: button-low cycles required to toggle mode (24-bit compare).
REQ-002 Parameter BYTE_TIMEOUT, default 4095: max cycles allowed between low and high byte of one word (12-bit compare).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 button  input  1  mode button, active-low, already synchronised externally.
REQ-006 rx_valid  input  1  one-cycle pulse, UART receiver byte available.
REQ-007 rx_data  input  8  received byte, valid when rx_valid=1.
REQ-008 ram_we  output  1  program RAM write strobe.
REQ-009 ram_waddr  output  8  program RAM write address.
REQ-010 ram_wdata  output  16  program RAM write data.
REQ-011 cpu_rst  output  1  CPU hold-in-reset, active-high.
REQ-012 mode  output  1  0 = load mode, 1 = run mode.
REQ-013 word_count  output  9  words written since entering load mode, saturates at 256.
REQ-014 load_err  output  1  sticky error: half word discarded.

Function
REQ-015 FSM states: LOAD_LO, LOAD_HI, WRITE, RUN; all registered.
REQ-016 LOAD_LO: rx_valid -> latch rx_data as low byte, clear timeout counter, go LOAD_HI.
REQ-017 LOAD_HI: rx_valid -> ram_wdata = {rx_data, low byte}, go WRITE.
REQ-018 LOAD_HI: timeout counter increments each cycle without rx_valid; reaching BYTE_TIMEOUT -> discard low byte, set load_err, go LOAD_LO.
REQ-019 WRITE: ram_we = 1 for exactly one cycle with ram_waddr at current address; next cycle ram_waddr increments, 255 wraps to 0.
REQ-020 WRITE: word_count increments, holds at 256 once reached; next state LOAD_LO.
REQ-021 rx_valid asserted in WRITE -> byte latched as low byte, next state LOAD_HI instead of LOAD_LO (no byte lost).
REQ-022 ram_wdata holds last written word when ram_we = 0.
REQ-023 Button: hold counter increments each cycle button = 0, clears when button = 1; mode toggle request pulses only when counter equals HOLD_CYCLES (once per press).
REQ-024 Counter stops at HOLD_CYCLES while held; no repeat toggles.
REQ-025 Toggle request in LOAD_LO -> RUN next cycle, mode = 1.
REQ-026 Toggle request in LOAD_HI -> discard low byte, set load_err, go RUN.
REQ-027 Toggle request in WRITE -> write completes this cycle (address/count updated), go RUN.
REQ-028 In RUN, rx_valid ignored; ram_we stays 0.
REQ-029 cpu_rst = 1 in all load states; deasserts one cycle after mode becomes 1.
REQ-030 Toggle request in RUN -> LOAD_LO; same cycle: mode = 0, cpu_rst = 1, ram_waddr = 0, word_count = 0, load_err = 0.

Reset
REQ-031 Reset: state LOAD_LO, mode 0, cpu_rst 1, ram_we 0, ram_waddr 0, ram_wdata 0, word_count 0, load_err 0, hold and timeout counters 0.
REQ-032 Reset mid-operation (any state, incl. WRITE) takes priority; no write strobe issued in the reset cycle or the following cycle.

Verification (HOLD_CYCLES=20, BYTE_TIMEOUT=50 on bench)
REQ-033 Bytes 0x34, 0x12 -> one ram_we pulse, addr 0, data 0x1234; word_count 1; ram_waddr 1.
REQ-034 257 words streamed -> word 256 writes addr 0 (wrap); word_count saturates at 256.
REQ-035 Byte 0xAA, then 60 idle cycles, then 0x01, 0x02 -> load_err 1; write data 0x0201 at next address; 0xAA never written.
REQ-036 Button low 100 cycles from LOAD_LO -> single toggle at cycle 20; mode 1; cpu_rst 0 one cycle later; rx bytes ignored.
REQ-037 Second 25-cycle press in RUN -> mode 0, cpu_rst 1, ram_waddr 0, word_count 0, load_err 0.
REQ-038 Reset asserted in LOAD_HI after low byte -> all outputs at reset values; next two bytes form word at addr 0.
